cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 137 +++++++++++++
 tb/tb_cpu_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Two-cycle accumulator CPU sequencer: FETCH reads the instruction word, EXEC performs the
// operand access or jump. A single shared tri-state data bus connects it to memory.
module cpu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [11:0] addr,
  inout  wire  [15:0] data,
  output logic        memrq,
  output logic        rnw,
  output logic [11:0] pc,
  output logic [15:0] acc,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_e;

  localparam logic [3:0] OpLda = 4'd0;
  localparam logic [3:0] OpSto = 4'd1;
  localparam logic [3:0] OpAdd = 4'd2;
  localparam logic [3:0] OpSub = 4'd3;
  localparam logic [3:0] OpJmp = 4'd4;
  localparam logic [3:0] OpJge = 4'd5;
  localparam logic [3:0] OpJne = 4'd6;
  localparam logic [3:0] OpStp = 4'd7;

  state_e      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] ir_q, ir_d;
  logic        halted_q, halted_d;
  logic        illegal_q, illegal_d;
  logic        drive_en;

  logic [3:0]  opcode;
  logic [11:0] operand;

  assign opcode  = ir_q[15:12];
  assign operand = ir_q[11:0];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    acc_d     = acc_q;
    ir_d      = ir_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    memrq     = 1'b0;
    rnw       = 1'b1;
    addr      = pc_q;
    drive_en  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        memrq   = 1'b1;
        ir_d    = data;
        pc_d    = pc_q + 12'd1;
        state_d = StExec;
      end
      StExec: begin
        state_d = StFetch;
        case (opcode)
          OpLda: begin
            memrq = 1'b1;
            addr  = operand;
            acc_d = data;
          end
          OpSto: begin
            memrq    = 1'b1;
            rnw      = 1'b0;
            addr     = operand;
            drive_en = 1'b1;
          end
          OpAdd: begin
            memrq = 1'b1;
            addr  = operand;
            acc_d = acc_q + data;
          end
          OpSub: begin
            memrq = 1'b1;
            addr  = operand;
            acc_d = acc_q - data;
          end
          OpJmp: pc_d = operand;
          OpJge: if (!acc_q[15]) pc_d = operand;
          OpJne: if (acc_q != 16'd0) pc_d = operand;
          OpStp: begin
            state_d  = StHalt;
            halted_d = 1'b1;
          end
          default: begin
            state_d   = StHalt;
            halted_d  = 1'b1;
            illegal_d = 1'b1;
          end
        endcase
      end
      StHalt: ;
    endcase

    // Kill any access as soon as rst is seen so an in-flight write never reaches the falling edge
    if (rst) begin
      memrq    = 1'b0;
      rnw      = 1'b1;
      drive_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= 12'd0;
      acc_q     <= 16'd0;
      ir_q      <= 16'd0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      acc_q     <= acc_d;
      ir_q      <= ir_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign data    = drive_en ? acc_q : 16'hzzzz;
  assign pc      = pc_q;
  assign acc     = acc_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a behavioural memory: combinational reads,
// writes captured on the falling edge.
module tb_cpu_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] addr;
  wire  [15:0] data;
  logic        memrq;
  logic        rnw;
  logic [11:0] pc;
  logic [15:0] acc;
  logic        halted;
  logic        illegal;

  logic [15:0] mem [4096];
  int errors = 0;
  int checks = 0;

  cpu_sequencer u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .addr    (addr),
    .data    (data),
    .memrq   (memrq),
    .rnw     (rnw),
    .pc      (pc),
    .acc     (acc),
    .halted  (halted),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign data = (memrq && rnw) ? mem[addr] : 16'hzzzz;

  always @(negedge clk) begin
    if (memrq && !rnw) mem[addr] = data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  // Edges after the start edge until halted; -1 if the budget expires
  task automatic run_to_halt(output int edges);
    edges = -1;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (halted) begin
        edges = n;
        return;
      end
    end
  endtask

  task automatic load_program(input logic [15:0] v065);
    clear_mem();
    mem[12'h000] = 16'h0064;
    mem[12'h001] = 16'h3065;
    mem[12'h002] = 16'h6006;
    mem[12'h003] = 16'h0064;
    mem[12'h004] = 16'h2065;
    mem[12'h005] = 16'h4009;
    mem[12'h006] = 16'h0064;
    mem[12'h007] = 16'h3066;
    mem[12'h008] = 16'h3066;
    mem[12'h009] = 16'h1064;
    mem[12'h00A] = 16'h7000;
    mem[12'h064] = 16'h4444;
    mem[12'h065] = v065;
    mem[12'h066] = 16'h1111;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    tick();
    checks++; if (pc !== 12'h000) begin errors++; $display("FAIL reset_pc: got %h want 000", pc); end
    checks++; if (acc !== 16'h0000) begin errors++; $display("FAIL reset_acc: got %h want 0000", acc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    checks++; if (memrq !== 1'b0) begin errors++; $display("FAIL reset_memrq: got %b want 0", memrq); end
    checks++; if (rnw !== 1'b1) begin errors++; $display("FAIL reset_rnw: got %b want 1", rnw); end
    rst   = 1'b0;
    start = 1'b0;
    tick();
    checks++; if (memrq !== 1'b0) begin errors++; $display("FAIL idle_memrq: got %b want 0", memrq); end
    checks++; if (addr !== 12'h000) begin errors++; $display("FAIL idle_addr: got %h want 000", addr); end
  endtask

  task automatic test_program_jne_taken();
    int edges;
    do_reset();
    load_program(16'h2222);
    pulse_start();
    checks++; if (memrq !== 1'b1 || rnw !== 1'b1 || addr !== 12'h000) begin
      errors++; $display("FAIL first_fetch: got memrq=%b rnw=%b addr=%h want 1 1 000", memrq, rnw, addr);
    end
    run_to_halt(edges);
    checks++; if (edges !== 16) begin errors++; $display("FAIL prog_edges: got %0d want 16", edges); end
    checks++; if (acc !== 16'h2222) begin errors++; $display("FAIL prog_acc: got %h want 2222", acc); end
    checks++; if (mem[12'h064] !== 16'h2222) begin errors++; $display("FAIL prog_mem064: got %h want 2222", mem[12'h064]); end
    checks++; if (pc !== 12'h00B) begin errors++; $display("FAIL prog_pc: got %h want 00B", pc); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL prog_illegal: got %b want 0", illegal); end
    pulse_start();
    tick();
    checks++; if (halted !== 1'b1 || pc !== 12'h00B || memrq !== 1'b0) begin
      errors++; $display("FAIL halt_hold: got halted=%b pc=%h memrq=%b want 1 00B 0", halted, pc, memrq);
    end
  endtask

  task automatic test_program_jne_not_taken();
    int edges;
    do_reset();
    load_program(16'h4444);
    pulse_start();
    run_to_halt(edges);
    checks++; if (edges !== 16) begin errors++; $display("FAIL jne_nt_edges: got %0d want 16", edges); end
    checks++; if (acc !== 16'h8888) begin errors++; $display("FAIL jne_nt_acc: got %h want 8888", acc); end
    checks++; if (mem[12'h064] !== 16'h8888) begin errors++; $display("FAIL jne_nt_mem064: got %h want 8888", mem[12'h064]); end
    checks++; if (pc !== 12'h00B) begin errors++; $display("FAIL jne_nt_pc: got %h want 00B", pc); end
  endtask

  task automatic test_jge();
    logic [15:0] vals [2];
    logic [11:0] want [2];
    vals[0] = 16'h8000; want[0] = 12'h002;
    vals[1] = 16'h7FFF; want[1] = 12'h020;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      clear_mem();
      mem[12'h000] = 16'h0010;
      mem[12'h001] = 16'h5020;
      mem[12'h002] = 16'h7000;
      mem[12'h020] = 16'h7000;
      mem[12'h010] = vals[k];
      pulse_start();
      repeat (4) tick();
      checks++; if (pc !== want[k]) begin
        errors++; $display("FAIL jge_pc[%0d]: got %h want %h", k, pc, want[k]);
      end
      repeat (2) tick();
      checks++; if (halted !== 1'b1 || illegal !== 1'b0) begin
        errors++; $display("FAIL jge_halt[%0d]: got halted=%b illegal=%b want 1 0", k, halted, illegal);
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    clear_mem();
    mem[12'h000] = 16'hF000;
    pulse_start();
    tick();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL ill_early: got halted=%b want 0", halted); end
    tick();
    checks++; if (halted !== 1'b1 || illegal !== 1'b1) begin
      errors++; $display("FAIL ill_flags: got halted=%b illegal=%b want 1 1", halted, illegal);
    end
    checks++; if (memrq !== 1'b0) begin errors++; $display("FAIL ill_memrq: got %b want 0", memrq); end
    tick();
    checks++; if (memrq !== 1'b0 || pc !== 12'h001) begin
      errors++; $display("FAIL ill_hold: got memrq=%b pc=%h want 0 001", memrq, pc);
    end
  endtask

  task automatic test_reset_mid_sto();
    do_reset();
    clear_mem();
    mem[12'h000] = 16'h0010;
    mem[12'h001] = 16'h1011;
    mem[12'h010] = 16'h1234;
    mem[12'h011] = 16'hABCD;
    pulse_start();
    repeat (3) tick();
    checks++; if (memrq !== 1'b1 || rnw !== 1'b0 || addr !== 12'h011 || data !== 16'h1234) begin
      errors++; $display("FAIL sto_drive: got memrq=%b rnw=%b addr=%h data=%h want 1 0 011 1234",
                         memrq, rnw, addr, data);
    end
    rst = 1'b1;
    #1;
    checks++; if (memrq !== 1'b0 || rnw !== 1'b1) begin
      errors++; $display("FAIL rst_comb: got memrq=%b rnw=%b want 0 1", memrq, rnw);
    end
    tick();
    rst = 1'b0;
    checks++; if (mem[12'h011] !== 16'hABCD) begin errors++; $display("FAIL rst_sto_mem: got %h want ABCD", mem[12'h011]); end
    checks++; if (pc !== 12'h000 || acc !== 16'h0000 || halted !== 1'b0 || illegal !== 1'b0) begin
      errors++; $display("FAIL rst_sto_regs: got pc=%h acc=%h halted=%b illegal=%b want 000 0000 0 0",
                         pc, acc, halted, illegal);
    end
    pulse_start();
    checks++; if (memrq !== 1'b1 || addr !== 12'h000) begin
      errors++; $display("FAIL restart_fetch: got memrq=%b addr=%h want 1 000", memrq, addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    clear_mem();
    mem[12'h000] = 16'h4FFF;
    mem[12'hFFF] = 16'h0010;
    mem[12'h010] = 16'h5A5A;
    pulse_start();
    repeat (2) tick();
    checks++; if (pc !== 12'hFFF) begin errors++; $display("FAIL wrap_jmp: got %h want FFF", pc); end
    tick();
    checks++; if (pc !== 12'h000) begin errors++; $display("FAIL wrap_pc: got %h want 000", pc); end
    tick();
    checks++; if (acc !== 16'h5A5A || addr !== 12'h000 || memrq !== 1'b1) begin
      errors++; $display("FAIL wrap_fetch: got acc=%h addr=%h memrq=%b want 5A5A 000 1", acc, addr, memrq);
    end
  endtask

  task automatic test_arith();
    int edges;
    do_reset();
    clear_mem();
    mem[12'h000] = 16'h0010;
    mem[12'h001] = 16'h2011;
    mem[12'h002] = 16'h1012;
    mem[12'h003] = 16'h0013;
    mem[12'h004] = 16'h3011;
    mem[12'h005] = 16'h7000;
    mem[12'h010] = 16'hFFFF;
    mem[12'h011] = 16'h0001;
    mem[12'h012] = 16'h5555;
    mem[12'h013] = 16'h0000;
    pulse_start();
    run_to_halt(edges);
    checks++; if (mem[12'h012] !== 16'h0000) begin errors++; $display("FAIL add_wrap: got %h want 0000", mem[12'h012]); end
    checks++; if (acc !== 16'hFFFF) begin errors++; $display("FAIL sub_wrap: got %h want FFFF", acc); end
    checks++; if (edges !== 12) begin errors++; $display("FAIL arith_edges: got %0d want 12", edges); end
  endtask

  task automatic test_self_loop();
    do_reset();
    clear_mem();
    mem[12'h000] = 16'h4000;
    pulse_start();
    repeat (6) tick();
    checks++; if (pc !== 12'h000 || halted !== 1'b0 || addr !== 12'h000 || memrq !== 1'b1) begin
      errors++; $display("FAIL self_loop: got pc=%h halted=%b addr=%h memrq=%b want 000 0 000 1",
                         pc, halted, addr, memrq);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    test_reset();
    test_program_jne_taken();
    test_program_jne_not_taken();
    test_jge();
    test_illegal();
    test_reset_mid_sto();
    test_wrap();
    test_arith();
    test_self_loop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
